// File: rtl/jesd_loop_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jesd_loop_pkg
//  Description : Shared definitions for the JESD204 loopback test sequencer.
//                Provides the FSM state encodings, the LED bit positions and
//                the default test length and lock depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package jesd_loop_pkg;

    // FSM state encodings
    localparam int                c_ST_W     = 3;
    localparam logic [c_ST_W-1:0] c_ST_IDLE  = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_ALIGN = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_RUN   = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_DONE  = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_FAIL  = 3'd4;

    // LED bit positions: led = {fail, pass, busy, tx_tready}
    localparam int c_LED_READY = 0;
    localparam int c_LED_BUSY  = 1;
    localparam int c_LED_PASS  = 2;
    localparam int c_LED_FAIL  = 3;

    // Default test sizing
    localparam int c_DEF_TEST_LEN = 1 << 20;
    localparam int c_DEF_LOCK_CNT = 16;

endpackage
`default_nettype wire

// File: rtl/jesd_trig_sync.sv
`default_nettype none
// ============================================================================
//  Module      : jesd_trig_sync
//  Description : STAGES-deep synchroniser for an asynchronous level input
//                followed by a registered rising-edge detector. o_rise is a
//                single-cycle pulse, STAGES+1 clocks after the input rises.
//  Ports       : clk      - destination clock
//                rst_n    - asynchronous active-low reset
//                i_async  - asynchronous level input (switch)
//                o_rise   - one-cycle rising-edge pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module jesd_trig_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/jesd_loop_test_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : jesd_loop_test_ctrl
//  Description : Sequencer/checker for the JESD204 TX->RX loopback. A trigger
//                rising edge starts an incrementing TX pattern; the checker
//                locks onto the looped-back RX words, checks TEST_LEN words
//                and reports pass/fail/error count on LEDs.
//  Ports       : sysclk_0  - system clock (only clock)
//                resetn_0  - asynchronous active-low reset
//                trig_in   - asynchronous trigger level
//                tx_tready - JESD TX ready, one word per cycle while high
//                tx_tdata  - TX pattern word
//                rx_tdata  - looped-back RX word, qualified by rx_tvalid
//                err_cnt   - saturating mismatch count from RUN
//                busy      - ALIGN or RUN in progress
//                pass/fail - test verdict
//                led       - {fail, pass, busy, tx_tready}
//  Revision    : 1.0 - initial release
// ============================================================================
module jesd_loop_test_ctrl
    import jesd_loop_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int TEST_LEN      = c_DEF_TEST_LEN,
    parameter int LOCK_CNT      = c_DEF_LOCK_CNT,
    parameter int ALIGN_TIMEOUT = 4096,
    parameter int ERR_W         = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              sysclk_0,
    input  logic              resetn_0,
    input  logic              trig_in,
    input  logic              tx_tready,
    output logic [DATA_W-1:0] tx_tdata,
    input  logic [DATA_W-1:0] rx_tdata,
    input  logic              rx_tvalid,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [3:0]        led
);

    localparam int c_WORD_W = $clog2(TEST_LEN + 1);
    localparam int c_TO_W   = $clog2(ALIGN_TIMEOUT + 1);
    localparam int c_LOCK_W = $clog2(LOCK_CNT + 1);

    // Counters fire on the cycle whose increment would reach the limit.
    localparam logic [c_WORD_W-1:0] c_WORD_LAST = c_WORD_W'(TEST_LEN - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(ALIGN_TIMEOUT - 1);
    localparam logic [c_LOCK_W-1:0] c_LOCK_LAST = c_LOCK_W'(LOCK_CNT - 1);
    localparam logic [ERR_W-1:0]    c_ERR_MAX   = '1;

    logic [c_ST_W-1:0]   r_state;
    logic [c_ST_W-1:0]   w_state_nxt;
    logic [DATA_W-1:0]   r_tx_data;
    logic [DATA_W-1:0]   r_last_rx;
    logic [DATA_W-1:0]   r_expected;
    logic [c_LOCK_W-1:0] r_lock_cnt;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [c_WORD_W-1:0] r_word_cnt;
    logic [ERR_W-1:0]    r_err_cnt;
    logic                r_busy;
    logic                r_pass;
    logic                r_fail;
    logic [3:0]          w_led;

    logic w_trig_rise;
    logic w_start;
    logic w_rx_step;
    logic w_lock_hit;
    logic w_timeout_hit;
    logic w_run_last;
    logic w_enter_align;

    jesd_trig_sync #(
        .STAGES (SYNC_STAGES)
    ) u_trig_sync (
        .clk     (sysclk_0),
        .rst_n   (resetn_0),
        .i_async (trig_in),
        .o_rise  (w_trig_rise)
    );

    // A test may only start while the TX link is accepting data.
    assign w_start       = w_trig_rise & tx_tready;
    assign w_rx_step     = (rx_tdata == r_last_rx + DATA_W'(1));
    assign w_lock_hit    = rx_tvalid && w_rx_step && (r_lock_cnt == c_LOCK_LAST);
    assign w_timeout_hit = (r_to_cnt == c_TO_LAST);
    assign w_run_last    = rx_tvalid && (r_word_cnt == c_WORD_LAST);
    assign w_enter_align = (w_state_nxt == c_ST_ALIGN) && (r_state != c_ST_ALIGN);

    always_ff @(posedge sysclk_0 or negedge resetn_0) begin
        if (!resetn_0) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE, c_ST_FAIL: begin
                if (w_start) begin
                    w_state_nxt = c_ST_ALIGN;
                end
            end
            c_ST_ALIGN: begin
                if (w_lock_hit) begin
                    w_state_nxt = c_ST_RUN;
                end else if (w_timeout_hit) begin
                    w_state_nxt = c_ST_FAIL;
                end
            end
            c_ST_RUN: begin
                // Completing the final word beats a simultaneous link drop.
                if (w_run_last) begin
                    w_state_nxt = c_ST_DONE;
                end else if (!tx_tready) begin
                    w_state_nxt = c_ST_FAIL;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk_0 or negedge resetn_0) begin
        if (!resetn_0) begin
            r_tx_data  <= '0;
            r_last_rx  <= '0;
            r_expected <= '0;
            r_lock_cnt <= '0;
            r_to_cnt   <= '0;
            r_word_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            // Pattern keeps running across retriggers; only ALIGN/RUN advance it.
            if (((r_state == c_ST_ALIGN) || (r_state == c_ST_RUN)) && tx_tready) begin
                r_tx_data <= r_tx_data + DATA_W'(1);
            end

            if (w_enter_align) begin
                r_lock_cnt <= '0;
                r_to_cnt   <= '0;
                r_word_cnt <= '0;
                r_err_cnt  <= '0;
            end else begin
                case (r_state)
                    c_ST_ALIGN: begin
                        r_to_cnt <= r_to_cnt + c_TO_W'(1);
                        if (rx_tvalid) begin
                            r_last_rx  <= rx_tdata;
                            // Only meaningful on the locking word, harmless otherwise.
                            r_expected <= rx_tdata + DATA_W'(1);
                            r_lock_cnt <= w_rx_step ? r_lock_cnt + c_LOCK_W'(1) : '0;
                        end
                    end
                    c_ST_RUN: begin
                        if (rx_tvalid) begin
                            if ((rx_tdata != r_expected) && (r_err_cnt != c_ERR_MAX)) begin
                                r_err_cnt <= r_err_cnt + ERR_W'(1);
                            end
                            // No resync: a bad word does not shift the expectation.
                            r_expected <= r_expected + DATA_W'(1);
                            r_word_cnt <= r_word_cnt + c_WORD_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Status flags are decoded from the current state, so they follow a
    // transition by one cycle.
    always_ff @(posedge sysclk_0 or negedge resetn_0) begin
        if (!resetn_0) begin
            r_busy <= 1'b0;
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else begin
            r_busy <= (r_state == c_ST_ALIGN) || (r_state == c_ST_RUN);
            r_pass <= (r_state == c_ST_DONE) && (r_err_cnt == '0);
            r_fail <= (r_state == c_ST_FAIL) || ((r_state == c_ST_DONE) && (r_err_cnt != '0));
        end
    end

    always_comb begin
        w_led              = '0;
        w_led[c_LED_READY] = tx_tready;
        w_led[c_LED_BUSY]  = r_busy;
        w_led[c_LED_PASS]  = r_pass;
        w_led[c_LED_FAIL]  = r_fail;
    end

    assign tx_tdata = r_tx_data;
    assign err_cnt  = r_err_cnt;
    assign busy     = r_busy;
    assign pass     = r_pass;
    assign fail     = r_fail;
    assign led      = w_led;

endmodule
`default_nettype wire
